// File: rtl/deriv_scan_ctrl.sv
// Raster scan controller for one Derivative unit: frame sequencing, tag capture and sink backpressure.
// Optional threshold comparator (thresh/out_edge ports) is enabled by defining DERIV_THRESH_EN.
module deriv_scan_ctrl #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int COL_W      = 6,
  parameter int ROW_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  output logic             pix_ready,
  output logic             deriv_enb,
  output logic             deriv_rst,
  output logic [7:0]       deriv_in,
  input  logic [7:0]       deriv_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [COL_W-1:0] out_col,
  output logic [ROW_W-1:0] out_row,
  output logic             busy,
  output logic             frame_done
`ifdef DERIV_THRESH_EN
  ,
  input  logic [7:0]       thresh,
  output logic             out_edge
`endif
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [7:0]       data;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
`ifdef DERIV_THRESH_EN
    logic             edg;
`endif
  } res_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, pcol_q, pcol_d;
  logic [ROW_W-1:0] row_q, row_d, prow_q, prow_d;
  logic             pend_q, pend_d;
  logic             skid_v_q, skid_v_d;
  logic             out_v_q, out_v_d;
  res_t             skid_q, skid_d, out_q, out_d, pend_rec;
  logic             accept, last_pix, out_free;

  assign pix_ready = (state_q == RUN) && !skid_v_q && !(pend_q && out_v_q && !out_ready);
  assign accept    = pix_valid && pix_ready;
  assign last_pix  = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign out_free  = !out_v_q || out_ready;

  // Column 0 has no left neighbour in this row, so its difference is meaningless.
  always_comb begin
    pend_rec      = '0;
    pend_rec.col  = pcol_q;
    pend_rec.row  = prow_q;
    pend_rec.data = (pcol_q == '0) ? 8'd0 : deriv_out;
`ifdef DERIV_THRESH_EN
    pend_rec.edg  = (pcol_q != '0) && (deriv_out >= thresh);
`endif
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: begin
        col_d   = '0;
        row_d   = '0;
        state_d = RUN;
      end
      RUN: if (accept) begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if (last_pix) state_d = DRAIN;
      end
      DRAIN: if (!pend_q && !skid_v_q && !out_v_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Skid drains ahead of pend so result order is preserved.
  always_comb begin
    pend_d   = accept;
    pcol_d   = accept ? col_q : pcol_q;
    prow_d   = accept ? row_q : prow_q;
    out_v_d  = out_v_q;
    out_d    = out_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (out_free) begin
      if (skid_v_q) begin
        out_v_d  = 1'b1;
        out_d    = skid_q;
        skid_v_d = pend_q;
        if (pend_q) skid_d = pend_rec;
      end else if (pend_q) begin
        out_v_d = 1'b1;
        out_d   = pend_rec;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (pend_q) begin
      skid_v_d = 1'b1;
      skid_d   = pend_rec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      pcol_q   <= '0;
      prow_q   <= '0;
      pend_q   <= 1'b0;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
      out_v_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      pcol_q   <= pcol_d;
      prow_q   <= prow_d;
      pend_q   <= pend_d;
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
      out_v_q  <= out_v_d;
      out_q    <= out_d;
    end
  end

  assign deriv_rst  = (state_q == CLEAR);
  assign deriv_enb  = deriv_rst || accept;
  assign deriv_in   = (state_q == RUN) ? pix_data : 8'd0;
  assign out_valid  = out_v_q;
  assign out_data   = out_q.data;
  assign out_col    = out_q.col;
  assign out_row    = out_q.row;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
`ifdef DERIV_THRESH_EN
  assign out_edge   = out_q.edg;
`endif

endmodule

// File: tb/tb_deriv_scan_ctrl.sv
// Directed bench for deriv_scan_ctrl on a 4x2 frame with a behavioural Derivative (|In - prev|).
module tb_deriv_scan_ctrl;
  localparam int W = 4, H = 2, CW = 2, RW = 1;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic          pix_valid = 1'b0, out_ready = 1'b1;
  logic [7:0]    pix_data = 8'd0;
  logic          pix_ready, deriv_enb, deriv_rst, out_valid, busy, frame_done;
  logic [7:0]    deriv_in, out_data;
  logic [7:0]    deriv_out = 8'd0, prev = 8'd0;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
`ifdef DERIV_THRESH_EN
  logic [7:0]    thresh = 8'd10;
  logic          out_edge;
`endif

  deriv_scan_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(CW), .ROW_W(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .deriv_enb(deriv_enb), .deriv_rst(deriv_rst), .deriv_in(deriv_in),
    .deriv_out(deriv_out), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .out_row(out_row), .busy(busy), .frame_done(frame_done)
`ifdef DERIV_THRESH_EN
    , .thresh(thresh), .out_edge(out_edge)
`endif
  );

  always #5 clk = ~clk;

  // Derivative unit: registered |In - prev|, output 0 when not enabled.
  always @(posedge clk) begin
    if (reset || deriv_rst) begin
      prev      <= 8'd0;
      deriv_out <= 8'd0;
    end else if (deriv_enb) begin
      deriv_out <= (deriv_in > prev) ? deriv_in - prev : prev - deriv_in;
      prev      <= deriv_in;
    end else begin
      deriv_out <= 8'd0;
    end
  end

  typedef struct {
    logic [7:0] pix;
    int         d;
    int         col;
    int         row;
    int         edg;
  } vec_t;
  vec_t vec [8];

  int checks = 0, failures = 0;
  int n_got, done_cnt, rst_cnt, acc_cyc, ov_cyc;
  int g_d [16];
  int g_c [16];
  int g_r [16];
  int g_e [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // mode: 0 plain, 1 sink stall, 2 source gaps, 3 start pulsed while busy.
  // Returns early after abort_n accepts when abort_n > 0.
  task automatic run_frame(input int mode, input int abort_n);
    int idx, post;
    logic hold;
    int hd, hc, hr;
    n_got = 0; done_cnt = 0; rst_cnt = 0; acc_cyc = -1; ov_cyc = -1;
    idx = 0; post = 0; hold = 1'b0; hd = 0; hc = 0; hr = 0;
    @(posedge clk); #1;
    for (int t = 0; t < 300; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      start     = (t == 0) || (mode == 3 && (t == 4 || t == 9));
      out_ready = !(mode == 1 && t >= 6 && t < 11);
      pix_valid = (idx < 8) && (mode != 2 || (t % 2) == 1);
      pix_data  = (idx < 8) ? vec[idx].pix : 8'd0;
      @(negedge clk);
      if (deriv_rst) rst_cnt++;
      if (hold) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), hd);
        chk("hold_col", int'(out_col), hc);
        chk("hold_row", int'(out_row), hr);
      end
      hold = out_valid && !out_ready;
      hd = int'(out_data); hc = int'(out_col); hr = int'(out_row);
      if (out_valid && ov_cyc < 0) ov_cyc = t;
      if (pix_valid && pix_ready) begin
        if (acc_cyc < 0) acc_cyc = t;
        idx++;
        if (idx == abort_n) return;
      end
      if (out_valid && out_ready && n_got < 16) begin
        g_d[n_got] = int'(out_data);
        g_c[n_got] = int'(out_col);
        g_r[n_got] = int'(out_row);
`ifdef DERIV_THRESH_EN
        g_e[n_got] = int'(out_edge);
`else
        g_e[n_got] = 0;
`endif
        n_got++;
      end
      if (frame_done) done_cnt++;
      if (done_cnt > 0) begin
        post++;
        if (post > 4) break;
      end
    end
    start = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_count"}, n_got, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_data%0d", tag, i), g_d[i], vec[i].d);
      chk($sformatf("%s_col%0d", tag, i), g_c[i], vec[i].col);
      chk($sformatf("%s_row%0d", tag, i), g_r[i], vec[i].row);
`ifdef DERIV_THRESH_EN
      chk($sformatf("%s_edge%0d", tag, i), g_e[i], vec[i].edg);
`endif
    end
    chk({tag, "_frame_done"}, done_cnt, 1);
    chk({tag, "_clear_pulses"}, rst_cnt, 1);
    chk({tag, "_idle_after"}, int'(busy), 0);
  endtask

  initial begin
    vec[0] = '{8'd10,  0,   0, 0, 0};
    vec[1] = '{8'd30,  20,  1, 0, 1};
    vec[2] = '{8'd25,  5,   2, 0, 0};
    vec[3] = '{8'd25,  0,   3, 0, 0};
    vec[4] = '{8'd200, 0,   0, 1, 0};
    vec[5] = '{8'd100, 100, 1, 1, 1};
    vec[6] = '{8'd110, 10,  2, 1, 1};
    vec[7] = '{8'd0,   110, 3, 1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pix_ready", int'(pix_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_deriv_rst", int'(deriv_rst), 0);
    chk("rst_deriv_enb", int'(deriv_enb), 0);
    chk("rst_out_data", int'(out_data), 0);
    #1 reset = 1'b0;

    // reset in the middle of a frame
    run_frame(0, 3);
    @(posedge clk); #1 reset = 1'b1; pix_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_pix_ready", int'(pix_ready), 0);
    @(posedge clk); #1 reset = 1'b0;

    run_frame(0, 0);
    check_frame("plain");
    chk("plain_latency", ov_cyc - acc_cyc, 2);

    run_frame(1, 0);
    check_frame("stall");

    run_frame(2, 0);
    check_frame("gaps");

    run_frame(3, 0);
    check_frame("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
